// File: rtl/seg_scan_driver_if.sv
// Display bus between the clock/alarm counters (master) and the seven-segment scanner (slave).
interface seg_scan_driver_if #(
  parameter int NUM_FIELDS = 3
);
  logic                      mode;
  logic [7*NUM_FIELDS-1:0]   src_a;
  logic [7*NUM_FIELDS-1:0]   src_b;
  logic [NUM_FIELDS-1:0]     blink_mask;
  logic                      lz_blank;
  logic [3:0]                brightness;
  logic [2*NUM_FIELDS-1:0]   digit_en;
  logic [7:0]                seg;

  modport master (
    output mode, src_a, src_b, blink_mask, lz_blank, brightness,
    input  digit_en, seg
  );

  modport slave (
    input  mode, src_a, src_b, blink_mask, lz_blank, brightness,
    output digit_en, seg
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-seg scanner with source select, field blink, 16-level PWM and guard band.
// Outputs lag slot_cnt by one cycle; no backpressure, display inputs are sampled once per slot.
module seg_scan_driver #(
  parameter int NUM_FIELDS   = 3,
  parameter int SCAN_DIV     = 10000,
  parameter int GUARD        = 4,
  parameter int BLINK_FRAMES = 50,
  parameter logic [2*NUM_FIELDS-1:0] DOT_MASK = '1
) (
  input logic              clk,
  input logic              rst_n,
  seg_scan_driver_if.slave disp
);
  localparam int DIGITS = 2 * NUM_FIELDS;
  localparam int SW     = $clog2(SCAN_DIV);
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int STEP   = SCAN_DIV / 16;

  logic [SW-1:0]           slot_cnt;
  logic [IW-1:0]           idx;
  logic [FW-1:0]           frame_cnt;
  logic                    blink_phase;
  logic                    fresh;
  logic [7*NUM_FIELDS-1:0] src_s;
  logic [NUM_FIELDS-1:0]   blink_s;
  logic                    lz_s;
  logic [3:0]              bright_s;

  logic                    slot_end;
  logic                    idx_wrap;
  logic                    frame_wrap;
  logic                    sample;
  logic [7*NUM_FIELDS-1:0] src_live;
  logic [7*NUM_FIELDS-1:0] src_e;
  logic [NUM_FIELDS-1:0]   blink_e;
  logic                    lz_e;
  logic [3:0]              bright_e;

  logic [IW-1:0]           fld;
  logic [6:0]              fval;
  logic [3:0]              dig;
  logic                    blank;
  logic                    on;
  logic [7:0]              seg_nxt;
  logic [DIGITS-1:0]       en_nxt;

  assign slot_end   = (slot_cnt == SW'(SCAN_DIV - 1));
  assign idx_wrap   = slot_end && (idx == IW'(DIGITS - 1));
  assign frame_wrap = idx_wrap && (frame_cnt == FW'(BLINK_FRAMES - 1));
  assign sample     = slot_end || fresh;
  assign src_live   = disp.mode ? disp.src_b : disp.src_a;

  // The very first slot after reset has no preceding slot end, so it runs on live inputs.
  assign src_e    = fresh ? src_live        : src_s;
  assign blink_e  = fresh ? disp.blink_mask : blink_s;
  assign lz_e     = fresh ? disp.lz_blank   : lz_s;
  assign bright_e = fresh ? disp.brightness : bright_s;

  always_comb begin
    fld     = idx >> 1;
    fval    = 7'(src_e >> (7 * fld));
    dig     = idx[0] ? 4'(fval / 7'd10) : 4'(fval % 7'd10);
    blank   = (|(blink_e & (NUM_FIELDS'(1) << fld)) && blink_phase) ||
              (lz_e && (idx == IW'(DIGITS - 1)) && (fval < 7'd10));
    seg_nxt = 8'hFF;
    if (!blank) begin
      seg_nxt[7] = |(DOT_MASK & (DIGITS'(1) << idx));
      if (fval > 7'd99) begin
        seg_nxt[6:0] = 7'b0111111;
      end else begin
        case (dig)
          4'd0:    seg_nxt[6:0] = 7'b1000000;
          4'd1:    seg_nxt[6:0] = 7'b1111001;
          4'd2:    seg_nxt[6:0] = 7'b0100100;
          4'd3:    seg_nxt[6:0] = 7'b0110000;
          4'd4:    seg_nxt[6:0] = 7'b0011001;
          4'd5:    seg_nxt[6:0] = 7'b0010010;
          4'd6:    seg_nxt[6:0] = 7'b0000010;
          4'd7:    seg_nxt[6:0] = 7'b1111000;
          4'd8:    seg_nxt[6:0] = 7'b0000000;
          4'd9:    seg_nxt[6:0] = 7'b0010000;
          default: seg_nxt[6:0] = 7'b1111111;
        endcase
      end
    end
    // Guard band at the slot start, PWM cut-off at (brightness+1)/16 of the slot.
    on     = (32'(slot_cnt) >= 32'(GUARD)) &&
             (32'(slot_cnt) < (32'(bright_e) + 32'd1) * 32'(STEP));
    en_nxt = on ? ~(DIGITS'(1) << idx) : '1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt      <= '0;
      idx           <= '0;
      frame_cnt     <= '0;
      blink_phase   <= 1'b0;
      fresh         <= 1'b1;
      src_s         <= '0;
      blink_s       <= '0;
      lz_s          <= 1'b0;
      bright_s      <= 4'd0;
      disp.digit_en <= '1;
      disp.seg      <= 8'hFF;
    end else begin
      fresh    <= 1'b0;
      slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
      if (slot_end) idx <= idx_wrap ? '0 : idx + 1'b1;
      if (idx_wrap) frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
      if (frame_wrap) blink_phase <= ~blink_phase;
      if (sample) begin
        src_s    <= src_live;
        blink_s  <= disp.blink_mask;
        lz_s     <= disp.lz_blank;
        bright_s <= disp.brightness;
      end
      disp.digit_en <= en_nxt;
      disp.seg      <= seg_nxt;
    end
  end
endmodule
